// File: rtl/my_ram8.sv
// my_ram8 -- eight-word register file with a sequential clear engine.
//
// The 3-bit address steers the single load strobe to exactly one word
// register through an 8-way one-hot demux. The addressed word is read back
// combinationally. A clear request starts a sweep that zeroes one word per
// cycle (word0 first, word7 last), then pulses clr_done for one cycle.
// Writes are accepted only while the engine is idle.
//
// Parameters:
//   WIDTH       data word width in bits (default 16)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset (words, counter, FSM)
//   in          write data
//   load        write strobe for word[address]
//   address     word select for write and read
//   out         read data, word[address] (combinational)
//   clr_req     request a full clear sweep, level-sampled in IDLE only
//   busy        high while the clear sweep is running
//   clr_done    one-cycle pulse when the sweep finishes
//
// Optional feature, macro MY_RAM8_PARITY_EN:
//   par_inject  when 1 during a write, the stored parity bit is inverted
//   parity_err  ^word[address] ^ par[address] (combinational)
module my_ram8 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done
`ifdef MY_RAM8_PARITY_EN
  ,
  input  logic             par_inject,
  output logic             parity_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [2:0]       cnt_reg;
  logic             busy_reg;
  logic             clr_done_reg;

  logic [WIDTH-1:0] word_reg [8];
  logic [7:0]       load_sel;
  logic [7:0]       clr_sel;
  logic             wr_allowed;
  logic             clr_active;

  // Writes are dropped (not queued) outside IDLE.
  assign wr_allowed = (state_reg == IDLE);
  assign clr_active = (state_reg == CLEAR);

  // Controller: registered busy/clr_done so both are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      busy_reg     <= 1'b0;
      clr_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          clr_done_reg <= 1'b0;
          if (clr_req) begin
            state_reg <= CLEAR;
            cnt_reg   <= 3'd0;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          // cnt wraps 7->0 here, harmless because we leave CLEAR at 7.
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
            state_reg    <= DONE;
            busy_reg     <= 1'b0;
            clr_done_reg <= 1'b1;
          end
        end
        DONE: begin
          state_reg    <= IDLE;
          clr_done_reg <= 1'b0;
        end
        default: begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          clr_done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign clr_done = clr_done_reg;

  // One-hot demux of the load strobe and of the sweep pointer.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
      assign load_sel[gi] = load && wr_allowed && (address == 3'(gi));
      assign clr_sel[gi]  = clr_active && (cnt_reg == 3'(gi));
    end
  endgenerate

  // Word registers: flops rather than block RAM, since reset must clear
  // every word asynchronously.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_word
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          word_reg[gi] <= '0;
        end else if (clr_sel[gi]) begin
          word_reg[gi] <= '0;
        end else if (load_sel[gi]) begin
          word_reg[gi] <= in;
        end
      end
    end
  endgenerate

  assign out = word_reg[address];

`ifdef MY_RAM8_PARITY_EN
  logic [7:0] par_reg;

  // Even parity: the stored bit equals the XOR of the data bits, so a
  // zero word with a zero parity bit is consistent after reset/clear.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_par
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          par_reg[gi] <= 1'b0;
        end else if (clr_sel[gi]) begin
          par_reg[gi] <= 1'b0;
        end else if (load_sel[gi]) begin
          par_reg[gi] <= (^in) ^ par_inject;
        end
      end
    end
  endgenerate

  assign parity_err = (^word_reg[address]) ^ par_reg[address];
`endif

endmodule

// File: tb/tb_my_ram8.sv
// tb_my_ram8 -- scoreboard bench for my_ram8.
// Stimulus pushes hand-computed expectations tagged with the cycle they
// belong to; a monitor on the falling edge pops and compares them.
module tb_my_ram8;

  localparam int WIDTH = 16;

  // Expectation kinds
  localparam int K_OUT  = 0;
  localparam int K_BUSY = 1;
  localparam int K_DONE = 2;
  localparam int K_PERR = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             load;
  logic [2:0]       address;
  logic [WIDTH-1:0] out;
  logic             clr_req;
  logic             busy;
  logic             clr_done;
`ifdef MY_RAM8_PARITY_EN
  logic             par_inject;
  logic             parity_err;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  my_ram8 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_data),
    .load      (load),
    .address   (address),
    .out       (out),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_done  (clr_done)
`ifdef MY_RAM8_PARITY_EN
    ,
    .par_inject(par_inject),
    .parity_err(parity_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      logic [15:0] act;
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_OUT:  act = out;
        K_BUSY: act = {15'd0, busy};
        K_DONE: act = {15'd0, clr_done};
`ifdef MY_RAM8_PARITY_EN
        K_PERR: act = {15'd0, parity_err};
`endif
        default: act = 16'hxxxx;
      endcase
      checks++;
      if (act !== mon_e.val || mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL %s cyc=%0d: got %h, expected %h (due cyc %0d)",
                 mon_e.name, cyc, act, mon_e.val, mon_e.cyc);
      end else begin
        $display("ok   %s cyc=%0d: %h", mon_e.name, cyc, act);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [15:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in_data = d;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    in_data = '0;
    load    = 1'b0;
    address = 3'd0;
    clr_req = 1'b0;
`ifdef MY_RAM8_PARITY_EN
    par_inject = 1'b0;
`endif
    step();
    expect_val(K_OUT,  16'h0000, "reset_out");
    expect_val(K_BUSY, 16'h0000, "reset_busy");
    expect_val(K_DONE, 16'h0000, "reset_done");
    step();
    reset = 1'b0;
    step();

    // Write 0x1000+i to address i; out shows the old (zero) value that cycle.
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      in_data = 16'h1000 + 16'(i);
      load    = 1'b1;
      expect_val(K_OUT, 16'h0000, $sformatf("pre_write_a%0d", i));
      step();
    end
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      expect_val(K_OUT, 16'h1000 + 16'(i), $sformatf("readback_a%0d", i));
      step();
    end

    // Write visibility and isolation.
    address = 3'd3;
    in_data = 16'hBEEF;
    load    = 1'b1;
    expect_val(K_OUT, 16'h1003, "beef_same_cycle");
    step();
    load = 1'b0;
    expect_val(K_OUT, 16'hBEEF, "beef_next_cycle");
    step();
    address = 3'd2;
    expect_val(K_OUT, 16'h1002, "neighbor_a2");
    step();
    address = 3'd4;
    expect_val(K_OUT, 16'h1004, "neighbor_a4");
    step();

    // Clear sweep with loads to address 5 held from the second CLEAR cycle
    // through DONE; none of them may land.
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'hFFFF);
    clr_req = 1'b1;
    step();                     // sampling edge
    clr_req = 1'b0;
    address = 3'd5;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) begin
        load    = 1'b1;
        in_data = 16'h1234;
      end
      expect_val(K_BUSY, 16'h0001, $sformatf("clr_busy_k%0d", k));
      expect_val(K_DONE, 16'h0000, $sformatf("clr_nodone_k%0d", k));
      // word5 is zeroed by the sixth sweep edge
      expect_val(K_OUT, (k <= 5) ? 16'hFFFF : 16'h0000, $sformatf("clr_out5_k%0d", k));
      step();
    end
    expect_val(K_BUSY, 16'h0000, "done_busy");
    expect_val(K_DONE, 16'h0001, "done_pulse");
    step();
    load = 1'b0;
    expect_val(K_DONE, 16'h0000, "done_pulse_end");
    expect_val(K_BUSY, 16'h0000, "idle_busy");
    step();
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      expect_val(K_OUT, 16'h0000, $sformatf("cleared_a%0d", i));
      step();
    end

    // Reset mid-sweep.
    write_word(3'd6, 16'h6666);
    clr_req = 1'b1;
    step();                     // sampling edge -> CLEAR cycle 1
    clr_req = 1'b0;
    address = 3'd6;
    step();
    step();
    step();                     // CLEAR cycle 4
    expect_val(K_BUSY, 16'h0001, "midsweep_busy");
    expect_val(K_OUT,  16'h6666, "midsweep_out6");
    step();
    #2;
    reset = 1'b1;
    expect_val(K_BUSY, 16'h0000, "async_reset_busy");
    expect_val(K_OUT,  16'h0000, "async_reset_out");
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_val(K_DONE, 16'h0000, $sformatf("no_done_k%0d", k));
      step();
    end
    write_word(3'd2, 16'h5A5A);
    address = 3'd2;
    expect_val(K_OUT, 16'h5A5A, "post_reset_write");
    step();

`ifdef MY_RAM8_PARITY_EN
    par_inject = 1'b0;
    write_word(3'd0, 16'h0001);
    par_inject = 1'b1;
    write_word(3'd1, 16'h0003);
    par_inject = 1'b0;
    address = 3'd0;
    expect_val(K_PERR, 16'h0000, "parity_ok_a0");
    step();
    address = 3'd1;
    expect_val(K_PERR, 16'h0001, "parity_err_a1");
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) step();
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      expect_val(K_PERR, 16'h0000, $sformatf("parity_cleared_a%0d", i));
      step();
    end
`endif

    step();
    step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
